clock_divider_multi: RTL and testbench

- Parametrised multi-channel successor to the fixed 100 MHz to 1 Hz divider.
- Each channel produces a 50% duty-cycle slow clock and a one-cycle tick pulse from the single system clock.
- The half-period of each channel is run-time programmable, with glitch-free reload.
- Used by display-scan, debounce and blink logic that each need different rates.

---
 rtl/clock_divider_multi.sv | 114 +++++++++++
 tb/tb_clock_divider_multi.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: 50% duty slow clocks plus rising-edge ticks.
// Optional macro CLKDIV_SYNC_EN adds a Sync input that restarts all channels phase-aligned.
module clock_divider_multi #(
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 32,
   parameter int unsigned DEFAULT_HALF = 50000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] Enable,
   input  logic              Div_Load,
   input  logic [2:0]        Div_Sel,
   input  logic [CNT_W-1:0]  Div_Value,
`ifdef CLKDIV_SYNC_EN
   input  logic              Sync,
`endif
   output logic              Load_Err,
   output logic [NUM_CH-1:0] Slow_Clock,
   output logic [NUM_CH-1:0] Tick
);

   localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
   localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);

   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  active_q [NUM_CH];
   logic [CNT_W-1:0]  active_d [NUM_CH];
   logic [CNT_W-1:0]  pend_q   [NUM_CH];
   logic [CNT_W-1:0]  pend_d   [NUM_CH];
   logic [NUM_CH-1:0] pvld_q, pvld_d;
   logic [NUM_CH-1:0] slow_q, slow_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] term;
   logic              err_q, err_d;
   logic              sel_ok, val_ok, load_ok;
   logic              sync_w;

`ifdef CLKDIV_SYNC_EN
   assign sync_w = Sync;
`else
   assign sync_w = 1'b0;
`endif

   assign sel_ok  = ({1'b0, Div_Sel} < NUM_CH_L);
   assign val_ok  = (Div_Value != '0);
   assign load_ok = Div_Load && sel_ok && val_ok;
   assign err_d   = Div_Load && !(sel_ok && val_ok);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         active_d[i] = active_q[i];
         pend_d[i]   = pend_q[i];
         pvld_d[i]   = pvld_q[i];
         slow_d[i]   = slow_q[i];
         tick_d[i]   = 1'b0;
         // >= rather than == keeps the counter bounded even if it ever exceeds the half-period
         term[i]     = (cnt_q[i] >= (active_q[i] - CNT_W'(1)));

         if (sync_w) begin
            cnt_d[i]  = '0;
            slow_d[i] = 1'b0;
         end else if (Enable[i]) begin
            if (term[i]) begin
               cnt_d[i]  = '0;
               slow_d[i] = ~slow_q[i];
               tick_d[i] = ~slow_q[i];
               if (pvld_q[i]) begin
                  active_d[i] = pend_q[i];
                  pvld_d[i]   = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end

         // A load on the terminal cycle lands after the apply above, so it waits a phase
         if (load_ok && (Div_Sel == 3'(i))) begin
            pend_d[i] = Div_Value;
            pvld_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            active_q[i] <= DEF_HALF;
            pend_q[i]   <= DEF_HALF;
         end
         pvld_q <= '0;
         slow_q <= '0;
         tick_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            active_q[i] <= active_d[i];
            pend_q[i]   <= pend_d[i];
         end
         pvld_q <= pvld_d;
         slow_q <= slow_d;
         tick_q <= tick_d;
         err_q  <= err_d;
      end
   end

   assign Slow_Clock = slow_q;
   assign Tick       = tick_q;
   assign Load_Err   = err_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi (2 channels, default half-period 4).
// Expected slow-clock waveforms are built from phase-length lists; ticks follow the rising edges.
module tb_clock_divider_multi;

   localparam int NCH = 2;
   localparam int CW  = 16;
   localparam int DH  = 4;

   logic           Clk = 1'b0;
   logic           Reset;
   logic [NCH-1:0] Enable;
   logic           Div_Load;
   logic [2:0]     Div_Sel;
   logic [CW-1:0]  Div_Value;
   logic           Load_Err;
   logic [NCH-1:0] Slow_Clock;
   logic [NCH-1:0] Tick;
`ifdef CLKDIV_SYNC_EN
   logic           Sync;
`endif

   int checks   = 0;
   int failures = 0;

   bit sq0[$];
   bit sq1[$];
   int errq[$];
   bit p0, p1;

   clock_divider_multi #(
      .NUM_CH(NCH),
      .CNT_W(CW),
      .DEFAULT_HALF(DH)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Enable(Enable),
      .Div_Load(Div_Load),
      .Div_Sel(Div_Sel),
      .Div_Value(Div_Value),
`ifdef CLKDIV_SYNC_EN
      .Sync(Sync),
`endif
      .Load_Err(Load_Err),
      .Slow_Clock(Slow_Clock),
      .Tick(Tick)
   );

   always #5 Clk = ~Clk;

   // Append alternating low/high phases (first l0, second l1, then lr) until the queue holds total samples
   task automatic push_run(input int ch, input int l0, input int l1, input int lr, input int total);
      bit lvl;
      int len;
      int k;
      lvl = 1'b0;
      len = l0;
      k   = 0;
      while (((ch == 0) ? sq0.size() : sq1.size()) < total) begin
         for (int i = 0; i < len; i++) begin
            if (ch == 0 && sq0.size() < total) sq0.push_back(lvl);
            if (ch == 1 && sq1.size() < total) sq1.push_back(lvl);
         end
         lvl = ~lvl;
         k++;
         len = (k == 1) ? l1 : lr;
      end
   endtask

   function automatic logic [4:0] pop_expected(input int j);
      bit s0, s1, e;
      s0 = 1'b0;
      s1 = 1'b0;
      e  = 1'b0;
      if (sq0.size() > 0) s0 = sq0.pop_front();
      if (sq1.size() > 0) s1 = sq1.pop_front();
      if (j == 0) begin
         p0 = 1'b0;
         p1 = 1'b0;
      end
      if (errq.size() > 0) begin
         if (errq[0] == j) begin
            e = 1'b1;
            void'(errq.pop_front());
         end
      end
      pop_expected = {e, s1 & ~p1, s0 & ~p0, s1, s0};
      p0 = s0;
      p1 = s1;
   endfunction

   task automatic apply_reset();
      Reset    = 1'b1;
      Div_Load = 1'b0;
      Enable   = '1;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      sq0.delete();
      sq1.delete();
      errq.delete();
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      Reset     = 1'b1;
      Div_Load  = 1'b1;
      Div_Sel   = 3'd0;
      Div_Value = 16'd1;
      for (int r = 0; r < 3; r++) begin
         @(negedge Clk);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state r=%0d got=%b want=%b", r, {Load_Err, Tick, Slow_Clock}, 5'b0);
         end
      end
      Reset    = 1'b0;
      Div_Load = 1'b0;
      sq0.delete(); sq1.delete(); errq.delete();
      push_run(0, 4, 4, 4, 24);
      push_run(1, 4, 4, 4, 24);
      for (int j = 0; j < 24; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL reset_run j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_reload();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 4, 4, 24);
      push_run(1, 4, 2, 2, 24);
      for (int j = 0; j < 24; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL reload j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         if (j == 1) begin Div_Load = 1'b1; Div_Sel = 3'd1; Div_Value = 16'd2; end
         @(negedge Clk);
      end
      Div_Load = 1'b0;
   endtask

   task automatic test_reject();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 4, 4, 24);
      push_run(1, 4, 4, 4, 24);
      for (int j = 0; j < 24; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL reject j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         if (j == 1) begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd0; errq.push_back(j + 1); end
         if (j == 5) begin Div_Load = 1'b1; Div_Sel = 3'd3; Div_Value = 16'd2; errq.push_back(j + 1); end
         @(negedge Clk);
      end
      Div_Load = 1'b0;
   endtask

   task automatic test_enable_hold();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 9, 4, 4, 26);
      push_run(1, 4, 4, 4, 26);
      for (int j = 0; j < 26; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL enable_hold j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         if (j == 2) Enable[0] = 1'b0;
         if (j == 7) Enable[0] = 1'b1;
         @(negedge Clk);
      end
   endtask

   task automatic test_load_one();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 1, 1, 20);
      push_run(1, 4, 4, 4, 20);
      for (int j = 0; j < 20; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL load_one j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         if (j == 0) begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd1; end
         @(negedge Clk);
      end
      Div_Load = 1'b0;
   endtask

   task automatic test_terminal_load();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 5, 5, 26);
      push_run(1, 4, 3, 2, 26);
      for (int j = 0; j < 26; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL terminal_load j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         if (j == 0) begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd3; end
         if (j == 1) begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd5; end
         if (j == 2) begin Div_Load = 1'b1; Div_Sel = 3'd1; Div_Value = 16'd3; end
         if (j == 3) begin Div_Load = 1'b1; Div_Sel = 3'd1; Div_Value = 16'd2; end
         @(negedge Clk);
      end
      Div_Load = 1'b0;
   endtask

   task automatic test_reset_pending();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 4, 4, 6);
      push_run(1, 4, 4, 4, 6);
      for (int j = 0; j < 6; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL reset_pending_pre j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         if (j == 4) begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd2; end
         if (j == 5) Reset = 1'b1;
         @(negedge Clk);
      end
      checks++;
      if ({Load_Err, Tick, Slow_Clock} !== 5'b0) begin
         failures++;
         $display("FAIL reset_pending_mid got=%b want=%b", {Load_Err, Tick, Slow_Clock}, 5'b0);
      end
      Reset = 1'b0;
      sq0.delete(); sq1.delete(); errq.delete();
      push_run(0, 4, 4, 4, 24);
      push_run(1, 4, 4, 4, 24);
      for (int j = 0; j < 24; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL reset_pending_post j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         @(negedge Clk);
      end
   endtask

`ifdef CLKDIV_SYNC_EN
   task automatic test_sync();
      logic [4:0] exp;
      apply_reset();
      push_run(0, 4, 3, 3, 18);
      push_run(1, 4, 5, 5, 18);
      push_run(0, 3, 3, 3, 32);
      push_run(1, 5, 5, 5, 32);
      for (int j = 0; j < 32; j++) begin
         exp = pop_expected(j);
         checks++;
         if ({Load_Err, Tick, Slow_Clock} !== exp) begin
            failures++;
            $display("FAIL sync j=%0d got=%b want=%b", j, {Load_Err, Tick, Slow_Clock}, exp);
         end
         Div_Load = 1'b0;
         Sync     = 1'b0;
         if (j == 0)  begin Div_Load = 1'b1; Div_Sel = 3'd0; Div_Value = 16'd3; end
         if (j == 1)  begin Div_Load = 1'b1; Div_Sel = 3'd1; Div_Value = 16'd5; end
         if (j == 17) Sync = 1'b1;
         @(negedge Clk);
      end
      Sync     = 1'b0;
      Div_Load = 1'b0;
   endtask
`endif

   initial begin
      Reset     = 1'b1;
      Enable    = '1;
      Div_Load  = 1'b0;
      Div_Sel   = 3'd0;
      Div_Value = '0;
`ifdef CLKDIV_SYNC_EN
      Sync      = 1'b0;
`endif
      test_reset();
      test_reload();
      test_reject();
      test_enable_hold();
      test_load_one();
      test_terminal_load();
      test_reset_pending();
`ifdef CLKDIV_SYNC_EN
      test_sync();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
